dyn_stream_mux: RTL and testbench
=================================

Name: dyn_stream_mux

Overview:
- Parametrised successor to the team's combinational select mux.
- Merges NUM_CH valid/ready streams into one registered output stream.
- Channel choice is either externally selected or round-robin, and is held for a whole packet (in_last-delimited).
- Sits between per-channel producers and a single downstream consumer. Adds one register stage with full-throughput backpressure.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 32, data width per channel.
- MODE, 0, 0 = external sel chooses the channel; 1 = round-robin arbitration (sel ignored).
- SEL_W, $clog2(NUM_CH), derived width of sel/out_ch; not to be overridden.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_valid  in  NUM_CH  per-channel beat valid
- in_last  in  NUM_CH  per-channel end-of-packet marker
- in_ready  out  NUM_CH  per-channel beat accepted (transfer when valid & ready)
- sel  in  SEL_W  channel select, used only when MODE=0
- out_data  out  DATA_W  registered output data
- out_valid  out  1  output beat valid
- out_last  out  1  registered last of output beat
- out_ch  out  SEL_W  source channel index of output beat
- out_ready  in  1  downstream accepts output beat
- busy  out  1  high while a packet is locked (state LOCKED)

Behaviour:
- Reset is synchronous: rst high at a clock edge forces state=IDLE, out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=NUM_CH-1.
  - With rr_ptr=NUM_CH-1, channel 0 has first round-robin priority.
  - Reset mid-packet discards the held output beat and the lock. No partial-packet recovery.
- Output register load enable: load = !out_valid || out_ready.
  - Latency input-to-output is 1 cycle. Full throughput of 1 beat/cycle under continuous out_ready.
  - If out_valid && !out_ready, out_* hold stable and all in_ready = 0.
- Grant (cand) selection in IDLE, combinational:
  - MODE=0: cand = sel, valid only if sel < NUM_CH and in_valid[sel]. Out-of-range sel means no grant.
  - MODE=1: cand = first i with in_valid[i], searching from rr_ptr+1 upward modulo NUM_CH.
  - No valid channel means no grant; state stays IDLE.
- FSM states are IDLE and LOCKED; g = granted channel register.
  - IDLE, cand exists:
    - in_ready[cand] = load.
    - If a beat transfers: capture into output register and set out_ch = cand.
    - If in_last[cand]=1, stay IDLE (single-beat packet) and set rr_ptr = cand.
    - Otherwise go to LOCKED with g = cand.
    - If load=0, nothing transfers and no lock is taken. Arbitration re-evaluates next cycle.
  - LOCKED:
    - in_ready[g] = load; all other in_ready = 0. sel changes and other channels' valids are ignored.
    - On a transfer with in_last[g]=1: go to IDLE and set rr_ptr = g.
    - in_valid[g]=0 in LOCKED inserts a bubble. Output behaviour in that cycle: if out_ready, out_valid falls to 0; otherwise the beat holds.
- in_ready is never asserted for more than one channel in a cycle. in_ready never depends on in_valid of the same channel, except through IDLE cand selection.
- busy = (state==LOCKED).
- out_data, out_last and out_ch change only on load with a transfer.
  - On load without a transfer, out_valid clears and data holds its previous value.
- Simultaneous events:
  - Last beat accepted while another channel is valid: the next packet is arbitrated in the following cycle (one IDLE cycle may overlap the transfer). There is no combinational back-to-back grant across packets within the same cycle.
  - rst overrides all inputs.

Test Plan:
- MODE=0, sel=2, ch2 sends 3 beats 0xA0,0xA1,0xA2(last) with out_ready=1 -> out beats 0xA0..0xA2 on consecutive cycles each 1 cycle later, out_ch=2, out_last on third, busy high during beats 1-2.
- MODE=0, sel switched 2->1 mid-packet on ch2 -> ch2 packet completes uninterrupted; in_ready[1]=0 until ch2 last accepted; ch1 packet follows.
- MODE=1, all 4 channels continuously valid with 2-beat packets -> grant order 0,1,2,3,0, each packet contiguous, out_ch matches.
- Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data/out_ch/out_last stable, all in_ready=0, no beat lost or duplicated on release.
- NUM_CH=3 with MODE=0, sel=3 and all valid -> no in_ready asserted, out_valid stays 0.
- rst pulsed while LOCKED with out_valid=1 -> next cycle out_valid=0, busy=0, out_ch=0; subsequent MODE=1 arbitration starts at channel 0.

Source files
------------

// File: rtl/dyn_stream_mux.sv
// Merges NUM_CH valid/ready streams into one registered output stream.
// The source channel is chosen by sel or round-robin and is held for a whole packet.
module dyn_stream_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int MODE   = 0,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready,
    output logic                     busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q;
    logic [SEL_W-1:0]  g_q;
    logic [SEL_W-1:0]  rr_ptr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [SEL_W-1:0]  out_ch_q;

    logic              load;
    logic [SEL_W-1:0]  cand;
    logic              cand_vld;
    logic [SEL_W-1:0]  gnt_ch;
    logic              gnt_vld;
    logic              gnt_valid_in;
    logic              gnt_last_in;
    logic [DATA_W-1:0] gnt_data_in;
    logic              xfer;

    assign load = !out_valid_q || out_ready;

    // An out-of-range sel never matches a channel, so it simply yields no grant.
    always_comb begin
        int idx;
        idx      = 0;
        cand     = '0;
        cand_vld = 1'b0;
        if (MODE == 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    cand     = SEL_W'(i);
                    cand_vld = 1'b1;
                end
            end
        end else begin
            // Walk the search order backwards so the nearest channel wins.
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = (int'(rr_ptr_q) + k) % NUM_CH;
                if (in_valid[idx]) begin
                    cand     = SEL_W'(idx);
                    cand_vld = 1'b1;
                end
            end
        end
    end

    assign gnt_ch  = (state_q == LOCKED) ? g_q : cand;
    assign gnt_vld = (state_q == LOCKED) || cand_vld;

    always_comb begin
        in_ready     = '0;
        gnt_valid_in = 1'b0;
        gnt_last_in  = 1'b0;
        gnt_data_in  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_ch == SEL_W'(i)) begin
                in_ready[i]  = gnt_vld && load;
                gnt_valid_in = in_valid[i];
                gnt_last_in  = in_last[i];
                gnt_data_in  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer = gnt_vld && load && gnt_valid_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            if (load) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= gnt_data_in;
                    out_last_q <= gnt_last_in;
                    out_ch_q   <= gnt_ch;
                end
            end
            if (xfer) begin
                if (gnt_last_in) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= gnt_ch;
                end else begin
                    state_q <= LOCKED;
                    g_q     <= gnt_ch;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_dyn_stream_mux.sv
// Directed bench for dyn_stream_mux: external-select, round-robin and
// three-channel instances share one set of input drivers.
module tb_dyn_stream_mux;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [1:0]   sel;
    logic         out_ready;

    logic [3:0]  u0_rdy, u1_rdy;
    logic [2:0]  u2_rdy;
    logic [31:0] u0_dat, u1_dat, u2_dat;
    logic        u0_ov, u1_ov, u2_ov;
    logic        u0_ol, u1_ol, u2_ol;
    logic [1:0]  u0_ch, u1_ch, u2_ch;
    logic        u0_bsy, u1_bsy, u2_bsy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dyn_stream_mux #(.NUM_CH(4), .DATA_W(32), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(u0_rdy), .sel(sel),
        .out_data(u0_dat), .out_valid(u0_ov), .out_last(u0_ol),
        .out_ch(u0_ch), .out_ready(out_ready), .busy(u0_bsy)
    );

    dyn_stream_mux #(.NUM_CH(4), .DATA_W(32), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(u1_rdy), .sel(sel),
        .out_data(u1_dat), .out_valid(u1_ov), .out_last(u1_ol),
        .out_ch(u1_ch), .out_ready(out_ready), .busy(u1_bsy)
    );

    dyn_stream_mux #(.NUM_CH(3), .DATA_W(32), .MODE(0)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data[95:0]),
        .in_valid(in_valid[2:0]), .in_last(in_last[2:0]),
        .in_ready(u2_rdy), .sel(sel),
        .out_data(u2_dat), .out_valid(u2_ov), .out_last(u2_ol),
        .out_ch(u2_ch), .out_ready(out_ready), .busy(u2_bsy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [1:0]  sel;
        logic        ordy;
        logic [7:0]  d;
        logic        chk_rdy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [31:0] e_dat;
        logic        e_last;
        logic [1:0]  e_ch;
        logic        e_busy;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_same(input logic [7:0] d);
        for (int i = 0; i < 4; i++)
            in_data[i*32 +: 32] = (32'(i) << 8) | 32'(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] cnt;
        logic [3:0] rdy;
        int         ech;

        rst = 1'b1; in_data = '0; in_valid = '0; in_last = '0;
        sel = '0; out_ready = 1'b1;

        //         rst vld      lst      sel ordy d      chk e_rdy    ov dat       lst ch bsy
        tbl[0]  = '{1, 4'b0000, 4'b0000, 0, 1, 8'h00, 0, 4'b0000, 0, 32'h000, 0, 0, 0};
        tbl[1]  = '{0, 4'b0100, 4'b0000, 2, 1, 8'hA0, 1, 4'b0100, 1, 32'h2A0, 0, 2, 1};
        tbl[2]  = '{0, 4'b0100, 4'b0000, 2, 1, 8'hA1, 1, 4'b0100, 1, 32'h2A1, 0, 2, 1};
        tbl[3]  = '{0, 4'b0100, 4'b0100, 2, 1, 8'hA2, 1, 4'b0100, 1, 32'h2A2, 1, 2, 0};
        tbl[4]  = '{0, 4'b0000, 4'b0000, 2, 1, 8'hA3, 1, 4'b0000, 0, 32'h2A2, 1, 2, 0};
        tbl[5]  = '{0, 4'b0110, 4'b0000, 2, 1, 8'hB0, 1, 4'b0100, 1, 32'h2B0, 0, 2, 1};
        tbl[6]  = '{0, 4'b0110, 4'b0000, 1, 1, 8'hB1, 1, 4'b0100, 1, 32'h2B1, 0, 2, 1};
        tbl[7]  = '{0, 4'b0110, 4'b0100, 1, 1, 8'hB2, 1, 4'b0100, 1, 32'h2B2, 1, 2, 0};
        tbl[8]  = '{0, 4'b0010, 4'b0010, 1, 1, 8'hC0, 1, 4'b0010, 1, 32'h1C0, 1, 1, 0};
        tbl[9]  = '{0, 4'b0010, 4'b0000, 1, 1, 8'hD0, 1, 4'b0010, 1, 32'h1D0, 0, 1, 1};
        tbl[10] = '{0, 4'b0010, 4'b0000, 1, 0, 8'hD1, 1, 4'b0000, 1, 32'h1D0, 0, 1, 1};
        tbl[11] = '{0, 4'b0010, 4'b0000, 1, 0, 8'hD1, 1, 4'b0000, 1, 32'h1D0, 0, 1, 1};
        tbl[12] = '{0, 4'b0010, 4'b0000, 1, 0, 8'hD1, 1, 4'b0000, 1, 32'h1D0, 0, 1, 1};
        tbl[13] = '{0, 4'b0010, 4'b0000, 1, 1, 8'hD1, 1, 4'b0010, 1, 32'h1D1, 0, 1, 1};
        tbl[14] = '{0, 4'b0010, 4'b0010, 1, 1, 8'hD2, 1, 4'b0010, 1, 32'h1D2, 1, 1, 0};
        tbl[15] = '{0, 4'b1000, 4'b0000, 3, 1, 8'hE0, 1, 4'b1000, 1, 32'h3E0, 0, 3, 1};
        tbl[16] = '{0, 4'b0000, 4'b0000, 3, 1, 8'hE1, 1, 4'b1000, 0, 32'h3E0, 0, 3, 1};
        tbl[17] = '{0, 4'b1000, 4'b1000, 3, 1, 8'hE1, 1, 4'b1000, 1, 32'h3E1, 1, 3, 0};
        tbl[18] = '{0, 4'b0001, 4'b0000, 0, 1, 8'hF0, 1, 4'b0001, 1, 32'h0F0, 0, 0, 1};
        tbl[19] = '{1, 4'b0001, 4'b0000, 0, 0, 8'hF1, 1, 4'b0000, 0, 32'h000, 0, 0, 0};
        tbl[20] = '{0, 4'b0000, 4'b0000, 0, 1, 8'h00, 1, 4'b0000, 0, 32'h000, 0, 0, 0};

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_last = tbl[i].lst;
            sel = tbl[i].sel; out_ready = tbl[i].ordy;
            drive_same(tbl[i].d);
            #1;
            if (tbl[i].chk_rdy)
                chk($sformatf("v%0d in_ready", i), 32'(u0_rdy), 32'(tbl[i].e_rdy));
            step();
            chk($sformatf("v%0d out_valid", i), 32'(u0_ov), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d out_data", i), u0_dat, tbl[i].e_dat);
            chk($sformatf("v%0d out_last", i), 32'(u0_ol), 32'(tbl[i].e_last));
            chk($sformatf("v%0d out_ch", i), 32'(u0_ch), 32'(tbl[i].e_ch));
            chk($sformatf("v%0d busy", i), 32'(u0_bsy), 32'(tbl[i].e_busy));
        end

        // Round-robin: all channels valid, 2-beat packets.
        rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("rr reset out_valid", 32'(u1_ov), 32'd0);
        chk("rr reset busy", 32'(u1_bsy), 32'd0);
        cnt = '0;
        for (int k = 0; k < 11; k++) begin
            in_valid = 4'b1111;
            in_last  = cnt;
            for (int i = 0; i < 4; i++)
                in_data[i*32 +: 32] = (32'(i) << 8) | 32'(cnt[i]);
            #1;
            rdy = u1_rdy;
            chk($sformatf("rr%0d onehot", k), 32'($countones(rdy) == 1), 32'd1);
            step();
            cnt = cnt ^ rdy;
            ech = (k / 2) % 4;
            chk($sformatf("rr%0d out_valid", k), 32'(u1_ov), 32'd1);
            chk($sformatf("rr%0d out_ch", k), 32'(u1_ch), 32'(ech));
            chk($sformatf("rr%0d out_last", k), 32'(u1_ol), 32'(k % 2));
            chk($sformatf("rr%0d out_data", k), u1_dat, (32'(ech) << 8) | 32'(k % 2));
        end

        // Reset while locked on channel 1 with a held beat.
        chk("rr locked busy", 32'(u1_bsy), 32'd1);
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0; out_ready = 1'b1;
        chk("rst out_valid", 32'(u1_ov), 32'd0);
        chk("rst busy", 32'(u1_bsy), 32'd0);
        chk("rst out_ch", 32'(u1_ch), 32'd0);
        cnt = '0;
        in_last = '0;
        for (int i = 0; i < 4; i++)
            in_data[i*32 +: 32] = (32'(i) << 8) | 32'h55;
        #1;
        chk("rst first in_ready", 32'(u1_rdy), 32'b0001);
        step();
        chk("rst first out_ch", 32'(u1_ch), 32'd0);
        chk("rst first out_data", u1_dat, 32'h055);

        // Three channels with out-of-range select.
        rst = 1'b1; in_valid = '0;
        step();
        rst = 1'b0;
        sel = 2'd3; in_valid = 4'b1111; in_last = 4'b1111;
        drive_same(8'h77);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("n3 sel3 in_ready %0d", k), 32'(u2_rdy), 32'd0);
            step();
            chk($sformatf("n3 sel3 out_valid %0d", k), 32'(u2_ov), 32'd0);
        end
        sel = 2'd1;
        #1;
        chk("n3 sel1 in_ready", 32'(u2_rdy), 32'b010);
        step();
        chk("n3 sel1 out_valid", 32'(u2_ov), 32'd1);
        chk("n3 sel1 out_ch", 32'(u2_ch), 32'd1);
        chk("n3 sel1 out_data", u2_dat, 32'h177);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
